uart_rx_os: RTL and testbench
=============================

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, >=8.
REQ-004 SHALL have parameter PARITY_EN, default 0, 1 = one parity bit after the data bits.
REQ-005 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, output queue entries; power of 2.
REQ-007 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data  output  8  data byte at the FIFO head.
REQ-011 SHALL have port rx_valid  output  1  FIFO non-empty; head entry valid.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts the head entry.
REQ-013 SHALL have port frame_err  output  1  head entry's stop bit was sampled low.
REQ-014 SHALL have port parity_err  output  1  head entry failed parity; always 0 when PARITY_EN=0.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped, FIFO full.
REQ-016 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of queued entries.

Function
REQ-017 SHALL synchronize rx through two flops, both reset to 1; all decoding uses the second flop.
REQ-018 SHALL generate a one-cycle tick every TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks from a free-running counter that wraps TICK_DIV-1 -> 0.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; all state activity advances only on tick cycles.
REQ-020 SHALL, in IDLE, enter START with sample counter 0 on the first tick where the synced rx is 0.
REQ-021 SHALL sample each bit at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit, with the bit value being the 2-of-3 majority.
REQ-022 SHALL, at the end of START (tick OVERSAMPLE-1), return to IDLE if the start majority is 1 (false start, nothing queued); otherwise enter DATA.
REQ-023 SHALL shift 8 data bits in LSB first, each bit lasting OVERSAMPLE ticks, then enter PARITY if PARITY_EN=1, else STOP.
REQ-024 SHALL set parity_err for the byte when the XOR of data and parity bit differs from PARITY_ODD.
REQ-025 SHALL, in STOP, decide the byte at the tick of the final majority sample (OVERSAMPLE/2+1): set frame_err if the majority is 0, push {parity_err, frame_err, data}, and return to IDLE on that same tick.
REQ-026 SHALL push bytes with frame_err set; no byte is suppressed for errors.
REQ-027 SHALL drive rx_valid, rx_data, frame_err and parity_err from registered FIFO state, valid the cycle after the push edge; push-to-rx_valid latency 1 clock.
REQ-028 SHALL pop the head entry on every cycle where rx_valid and rx_ready are both 1; rx_ready while empty has no effect.
REQ-029 SHALL, on push while full with no pop, drop the new entry, keep the FIFO unchanged and pulse overrun for 1 cycle.
REQ-030 SHALL, on push and pop in the same cycle, accept both with fifo_count unchanged, including when full (no overrun).
REQ-031 SHALL hold rx_data and the flags stable while rx_valid=1 and rx_ready=0.
REQ-032 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-033 SHALL, while rst=1, force state IDLE, tick counter 0, sync flops 1, FIFO empty, fifo_count 0, rx_valid 0, overrun 0, frame_err 0, parity_err 0, rx_data 8'h00.
REQ-034 SHALL discard any partially received byte when rst is asserted mid-frame, and queue nothing for it after release.

Verification
REQ-035 Clean byte: CLK_FREQ=3_200_000, BAUD=100_000, OVERSAMPLE=16, send 8'hA5 with stop=1 -> rx_valid, rx_data=8'hA5, frame_err=0, fifo_count=1.
REQ-036 Glitch: rx low for 3 ticks then high in IDLE -> false start, FIFO stays empty, next byte 8'h3C received correctly.
REQ-037 Framing: send 8'h55 with stop bit 0 -> entry rx_data=8'h55, frame_err=1; next byte with a good stop bit -> frame_err=0.
REQ-038 Parity: PARITY_EN=1, PARITY_ODD=0, send 8'h07 with parity 0 -> parity_err=1; with parity 1 -> parity_err=0.
REQ-039 Overrun: rx_ready=0, send 5 bytes 8'h01..8'h05 at FIFO_DEPTH=4 -> fifo_count=4, overrun one pulse on the 5th byte, pops return 01,02,03,04.
REQ-040 Reset mid-frame: assert rst for 2 clocks during data bit 4 of 8'hFF -> fifo_count=0, no entry queued, next byte 8'h81 received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 2-of-3 mid-bit majority voting, optional parity
// check and a small output FIFO that carries per-byte framing/parity error flags.
module uart_rx_os #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] S_LO      = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_MID     = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S_HI      = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] S_END     = CW'(OVERSAMPLE - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   FC_ZERO   = (AW + 1)'(0);
    localparam logic [AW:0]   FC_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FC_FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_fail(input logic [7:0] d, input logic p);
        return ((^d) ^ p) != (PARITY_ODD != 0);
    endfunction

    logic          rx_meta_q, rx_sync_q;
    logic [TW-1:0] tick_cnt_q;
    logic          tick_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    samp_q, samp_d;
    logic          bit_q, bit_d;
    logic          maj_s, push_s, perr_s;
    logic [9:0]    push_word_s;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          overrun_q, full_s, pop_s, push_ok_s;
    logic [9:0]    head_s;

    assign tick_s = (tick_cnt_q == TICK_LAST);

    // Input synchronizer and free-running oversample tick divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            tick_cnt_q <= tick_s ? '0 : tick_cnt_q + TICK_ONE;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            samp_q    <= 2'b11;
            bit_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
        end
    end

    assign maj_s       = maj3(samp_q[0], samp_q[1], rx_sync_q);
    assign perr_s      = (PARITY_EN != 0) ? parity_fail(shift_q, bit_q) : 1'b0;
    assign push_word_s = {perr_s, ~maj_s, shift_q};

    // Frame decoder: the majority is resolved on the third sample tick of each bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        push_s    = 1'b0;
        if (!tick_s) begin
            state_d = state_q;
        end else if (state_q == IDLE) begin
            cnt_d = CNT_ZERO;
            if (!rx_sync_q) begin
                state_d = START;
            end else begin
                state_d = IDLE;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == S_LO) begin
                samp_d[0] = rx_sync_q;
            end else if (cnt_q == S_MID) begin
                samp_d[1] = rx_sync_q;
            end else if (cnt_q == S_HI) begin
                case (state_q)
                    DATA:    shift_d = {maj_s, shift_q[7:1]};
                    STOP: begin
                        push_s  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                    default: bit_d = maj_s;
                endcase
            end else if (cnt_q == S_END) begin
                cnt_d = CNT_ZERO;
                case (state_q)
                    START: begin
                        bit_idx_d = 3'd0;
                        state_d   = bit_q ? IDLE : DATA;
                    end
                    DATA: begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            state_d = DATA;
                        end
                    end
                    PARITY:  state_d = STOP;
                    default: state_d = IDLE;
                endcase
            end else begin
                samp_d = samp_q;
            end
        end
    end

    assign full_s    = (count_q == FC_FULL);
    assign pop_s     = rx_valid & rx_ready;
    assign push_ok_s = push_s & (~full_s | pop_s);

    // FIFO storage; contents are only observable through count-gated outputs.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= push_word_s;
        end
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= FC_ZERO;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push_s & full_s & ~pop_s;
            if (push_ok_s) begin
                wr_q <= wr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_q <= rd_q + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_q <= count_q + FC_ONE;
                2'b01:   count_q <= count_q - FC_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_s     = mem_q[rd_q];
    assign rx_valid   = (count_q != FC_ZERO);
    assign rx_data    = rx_valid ? head_s[7:0] : 8'h00;
    assign frame_err  = rx_valid ? head_s[8] : 1'b0;
    assign parity_err = rx_valid ? head_s[9] : 1'b0;
    assign overrun    = overrun_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench: instance A (no parity) and instance B (even parity) at 100 kbaud, 16x.
module tb_uart_rx_os;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       val_a, val_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
    logic [2:0] cnt_a, cnt_b;
    int checks = 0;
    int failures = 0;
    int ov_cycles = 0;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                 .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a),
        .fifo_count(cnt_a));

    uart_rx_os #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                 .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b),
        .fifo_count(cnt_b));

    always @(posedge clk) begin
        if (ov_a) ov_cycles <= ov_cycles + 1;
    end

    // One bit time is 32 clocks (tick every 2 clocks, 16 ticks per bit).
    task automatic drive_bit(input int sel, input logic b);
        @(negedge clk);
        if (sel == 0) rx_a = b; else rx_b = b;
        repeat (31) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic stop_b,
                        input logic use_par, input logic par_b);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (use_par) drive_bit(sel, par_b);
        drive_bit(sel, stop_b);
        drive_bit(sel, 1'b1);
        drive_bit(sel, 1'b1);
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        if (sel == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (val_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", val_a); end
        checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_a); end
        checks++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {fe_a, pe_a, ov_a}); end
        checks++; if ({val_b, cnt_b} !== 4'b0000) begin failures++; $display("FAIL reset_b got=%b exp=0000", {val_b, cnt_b}); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_clean();
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        checks++; if (val_a !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", val_a); end
        checks++; if (data_a !== 8'hA5) begin failures++; $display("FAIL clean_data got=%h exp=a5", data_a); end
        checks++; if (fe_a !== 1'b0) begin failures++; $display("FAIL clean_fe got=%b exp=0", fe_a); end
        checks++; if (cnt_a !== 3'd1) begin failures++; $display("FAIL clean_count got=%0d exp=1", cnt_a); end
        pop(0);
        checks++; if ({val_a, cnt_a} !== 4'b0000) begin failures++; $display("FAIL clean_pop got=%b exp=0000", {val_a, cnt_a}); end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx_a = 1'b0;
        repeat (6) @(negedge clk);
        rx_a = 1'b1;
        repeat (80) @(negedge clk);
        checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL glitch_empty got=%0d exp=0", cnt_a); end
        send(0, 8'h3C, 1'b1, 1'b0, 1'b0);
        checks++; if ({cnt_a, data_a} !== {3'd1, 8'h3C}) begin failures++; $display("FAIL glitch_next got=%0d/%h exp=1/3c", cnt_a, data_a); end
        pop(0);
    endtask

    task automatic test_framing();
        send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if ({data_a, fe_a} !== {8'h55, 1'b1}) begin failures++; $display("FAIL frame_bad got=%h/%b exp=55/1", data_a, fe_a); end
        checks++; if (cnt_a !== 3'd1) begin failures++; $display("FAIL frame_count got=%0d exp=1", cnt_a); end
        pop(0);
        send(0, 8'h5A, 1'b1, 1'b0, 1'b0);
        checks++; if ({val_a, data_a, fe_a} !== {1'b1, 8'h5A, 1'b0}) begin failures++; $display("FAIL frame_good got=%b/%h/%b exp=1/5a/0", val_a, data_a, fe_a); end
        pop(0);
    endtask

    task automatic test_parity();
        send(1, 8'h07, 1'b1, 1'b1, 1'b0);
        checks++; if ({val_b, data_b, pe_b} !== {1'b1, 8'h07, 1'b1}) begin failures++; $display("FAIL parity_bad got=%b/%h/%b exp=1/07/1", val_b, data_b, pe_b); end
        pop(1);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1);
        checks++; if ({val_b, data_b, pe_b, fe_b} !== {1'b1, 8'h07, 1'b0, 1'b0}) begin failures++; $display("FAIL parity_good got=%b/%h/%b/%b exp=1/07/0/0", val_b, data_b, pe_b, fe_b); end
        pop(1);
        checks++; if (pe_a !== 1'b0) begin failures++; $display("FAIL parity_disabled got=%b exp=0", pe_a); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_d;
        ov_cycles = 0;
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b1, 1'b0, 1'b0);
        checks++; if (cnt_a !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", cnt_a); end
        checks++; if (ov_cycles !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cycles); end
        for (int i = 1; i <= 4; i++) begin
            exp_d = 8'(i);
            checks++; if ({val_a, data_a} !== {1'b1, exp_d}) begin failures++; $display("FAIL ovr_pop got=%b/%h exp=1/%h", val_a, data_a, exp_d); end
            pop(0);
        end
        checks++; if ({val_a, cnt_a} !== 4'b0000) begin failures++; $display("FAIL ovr_drained got=%b exp=0000", {val_a, cnt_a}); end
    endtask

    task automatic test_reset_midframe();
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        @(negedge clk);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        checks++; if ({val_a, cnt_a} !== 4'b0000) begin failures++; $display("FAIL rstmid_empty got=%b exp=0000", {val_a, cnt_a}); end
        send(0, 8'h81, 1'b1, 1'b0, 1'b0);
        checks++; if ({cnt_a, data_a, fe_a} !== {3'd1, 8'h81, 1'b0}) begin failures++; $display("FAIL rstmid_next got=%0d/%h/%b exp=1/81/0", cnt_a, data_a, fe_a); end
        pop(0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_glitch();
        test_framing();
        test_parity();
        test_overrun();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
